// File: rtl/asic_latch_ram_pkg.sv
// Shared types for the latch-RAM write scheduler and its arbiter.
package asic_latch_ram_pkg;

    typedef enum logic {
        WS_INIT = 1'b0,
        WS_RUN  = 1'b1
    } write_sched_state_t;

    // Index width for an N-way selection; a 1-way selection still carries a 1-bit index.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/std_rr_arbiter.sv
// Round-robin arbiter: first valid requester at or above the pointer, with wrap.
// Purely combinational; the caller owns and advances the pointer.
module std_rr_arbiter
    import asic_latch_ram_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    localparam int IW      = idx_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] valid,
    input  logic [IW-1:0]      pointer,
    output logic [NUM_REQ-1:0] grant,
    output logic [IW-1:0]      grant_idx,
    output logic               grant_vld
);

    logic [NUM_REQ-1:0] w_rot;
    logic [IW-1:0]      w_off;
    logic [IW:0]        w_sum;

    // Bit k of the rotated vector is requester (pointer + k) mod NUM_REQ.
    assign w_rot = NUM_REQ'({valid, valid} >> pointer);

    always_comb begin
        w_off     = '0;
        grant_vld = 1'b0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                grant_vld = 1'b1;
                w_off     = IW'(k);
            end
        end
    end

    always_comb begin
        w_sum = {1'b0, pointer} + {1'b0, w_off};
        if (w_sum >= (IW + 1)'(NUM_REQ)) begin
            grant_idx = IW'(w_sum - (IW + 1)'(NUM_REQ));
        end else begin
            grant_idx = w_sum[IW-1:0];
        end
    end

    always_comb begin
        grant = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            grant[i] = grant_vld && (grant_idx == IW'(i));
        end
    end

endmodule

// File: rtl/asic_latch_ram_write_sched.sv
// Owns the latch-RAM write port: init sweep after reset/clear, then round-robin writer grants.
// One registered write per cycle; req_ready is combinational and only asserted in RUN without clear.
module asic_latch_ram_write_sched
    import asic_latch_ram_pkg::*;
#(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 5,
    parameter int                    NUM_REQ    = 4,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  clear,
    input  logic [NUM_REQ-1:0]                    req_valid,
    input  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0]    req_addr,
    input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]    req_data,
    output logic [NUM_REQ-1:0]                    req_ready,
    output logic                                  init_done,
    output logic                                  write_enable,
    output logic [ADDR_WIDTH-1:0]                 write_addr,
    output logic [DATA_WIDTH-1:0]                 write_data_in
);

    localparam int                IW        = idx_width(NUM_REQ);
    localparam logic [ADDR_WIDTH:0] LAST_ADDR = (ADDR_WIDTH + 1)'((1 << ADDR_WIDTH) - 1);

    write_sched_state_t    r_state;
    logic [ADDR_WIDTH:0]   r_ctr;
    logic [IW-1:0]         r_ptr;
    logic                  r_init_done;
    logic                  r_we;
    logic [ADDR_WIDTH-1:0] r_waddr;
    logic [DATA_WIDTH-1:0] r_wdata;

    logic [NUM_REQ-1:0]    w_grant;
    logic [IW-1:0]         w_grant_idx;
    logic                  w_grant_vld;
    logic                  w_accept;
    logic [IW-1:0]         w_ptr_nxt;

    std_rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .valid     (req_valid),
        .pointer   (r_ptr),
        .grant     (w_grant),
        .grant_idx (w_grant_idx),
        .grant_vld (w_grant_vld)
    );

    // A clear cycle grants nothing so no writer believes its write survived the re-init.
    assign w_accept  = (r_state == WS_RUN) && !clear && w_grant_vld;
    assign req_ready = w_accept ? w_grant : '0;
    assign w_ptr_nxt = (w_grant_idx == IW'(NUM_REQ - 1)) ? '0 : w_grant_idx + IW'(1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= WS_INIT;
            r_ctr       <= '0;
            r_ptr       <= '0;
            r_init_done <= 1'b0;
            r_we        <= 1'b0;
            r_waddr     <= '0;
            r_wdata     <= '0;
        end else if (clear) begin
            r_state     <= WS_INIT;
            r_ctr       <= '0;
            r_init_done <= 1'b0;
            r_we        <= 1'b0;
        end else begin
            case (r_state)
                WS_INIT: begin
                    r_we    <= 1'b1;
                    r_waddr <= r_ctr[ADDR_WIDTH-1:0];
                    r_wdata <= INIT_VALUE;
                    r_ctr   <= r_ctr + (ADDR_WIDTH + 1)'(1);
                    if (r_ctr == LAST_ADDR) begin
                        r_state     <= WS_RUN;
                        r_init_done <= 1'b1;
                    end
                end
                WS_RUN: begin
                    r_we <= w_accept;
                    if (w_accept) begin
                        r_waddr <= req_addr[w_grant_idx];
                        r_wdata <= req_data[w_grant_idx];
                        r_ptr   <= w_ptr_nxt;
                    end
                end
                default: begin
                    r_state <= WS_INIT;
                end
            endcase
        end
    end

    assign init_done     = r_init_done;
    assign write_enable  = r_we;
    assign write_addr    = r_waddr;
    assign write_data_in = r_wdata;

    a_ready_onehot: assert property (@(posedge clk) disable iff (!rst) $onehot0(req_ready));
    a_ready_in_run: assert property (@(posedge clk) disable iff (!rst)
                                     (req_ready != '0) |-> (r_state == WS_RUN));

endmodule

// File: tb/tb_asic_latch_ram_write_sched.sv
// Directed bench for the latch-RAM write scheduler with a behavioural RAM on the write port.
module tb_asic_latch_ram_write_sched;

    localparam int          DW    = 32;
    localparam int          AW    = 5;
    localparam int          NR    = 4;
    localparam int          DEPTH = 1 << AW;
    localparam logic [DW-1:0] INIT = 32'hDEAD;

    logic                     clk;
    logic                     rst;
    logic                     clear;
    logic [NR-1:0]            req_valid;
    logic [NR-1:0][AW-1:0]    req_addr;
    logic [NR-1:0][DW-1:0]    req_data;
    logic [NR-1:0]            req_ready;
    logic                     init_done;
    logic                     write_enable;
    logic [AW-1:0]            write_addr;
    logic [DW-1:0]            write_data_in;

    logic [DW-1:0] mem [DEPTH];

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [NR-1:0]         valid;
        logic [NR-1:0][AW-1:0] addr;
        logic [NR-1:0][DW-1:0] data;
        logic [NR-1:0]         exp_ready;
        logic                  exp_we;
        logic [AW-1:0]         exp_addr;
        logic [DW-1:0]         exp_data;
    } vec_t;

    vec_t tbl [13];

    asic_latch_ram_write_sched #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .NUM_REQ    (NR),
        .INIT_VALUE (INIT)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .clear         (clear),
        .req_valid     (req_valid),
        .req_addr      (req_addr),
        .req_data      (req_data),
        .req_ready     (req_ready),
        .init_done     (init_done),
        .write_enable  (write_enable),
        .write_addr    (write_addr),
        .write_data_in (write_data_in)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (write_enable) mem[write_addr] <= write_data_in;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [NR-1:0] v, input logic [NR-1:0][AW-1:0] a,
                                input logic [NR-1:0][DW-1:0] d, input logic [NR-1:0] er,
                                input logic ew, input logic [AW-1:0] ea, input logic [DW-1:0] ed);
        vec_t r;
        r.valid = v; r.addr = a; r.data = d;
        r.exp_ready = er; r.exp_we = ew; r.exp_addr = ea; r.exp_data = ed;
        return r;
    endfunction

    // Drive one cycle of requests, check ready before the edge and the write regs after it.
    task automatic apply(input vec_t v, input string tag);
        req_valid = v.valid;
        req_addr  = v.addr;
        req_data  = v.data;
        #1;
        chk($sformatf("%s_ready", tag), req_ready, v.exp_ready);
        @(posedge clk); #1;
        chk($sformatf("%s_we", tag), write_enable, v.exp_we);
        chk($sformatf("%s_addr", tag), write_addr, v.exp_addr);
        chk($sformatf("%s_data", tag), write_data_in, v.exp_data);
    endtask

    task automatic check_sweep(input string tag);
        for (int i = 0; i < DEPTH; i++) begin
            chk($sformatf("%s_ready%0d", tag, i), req_ready, '0);
            @(posedge clk); #1;
            chk($sformatf("%s_we%0d", tag, i), write_enable, 1'b1);
            chk($sformatf("%s_addr%0d", tag, i), write_addr, i);
            chk($sformatf("%s_data%0d", tag, i), write_data_in, INIT);
            chk($sformatf("%s_done%0d", tag, i), init_done, (i == DEPTH - 1));
        end
    endtask

    initial begin
        logic [DW-1:0] base;
        tbl[0]  = mk(4'b0101, {5'd0, 5'd2, 5'd0, 5'd1}, {32'h0, 32'h69, 32'h0, 32'h42},
                     4'b0001, 1'b1, 5'd1, 32'h42);
        tbl[1]  = mk(4'b0100, {5'd0, 5'd2, 5'd0, 5'd1}, {32'h0, 32'h69, 32'h0, 32'h42},
                     4'b0100, 1'b1, 5'd2, 32'h69);
        tbl[2]  = mk(4'b0000, {5'd0, 5'd2, 5'd0, 5'd1}, {32'h0, 32'h69, 32'h0, 32'h42},
                     4'b0000, 1'b0, 5'd2, 32'h69);
        tbl[3]  = mk(4'b1000, {5'd8, 5'd0, 5'd0, 5'd0}, {32'h77, 32'h0, 32'h0, 32'h0},
                     4'b1000, 1'b1, 5'd8, 32'h77);
        for (int k = 0; k < 8; k++) begin
            base = (k < 4) ? 32'h100 : 32'h200;
            tbl[4+k] = mk(4'b1111, {5'd7, 5'd6, 5'd5, 5'd4},
                          {base + 32'd3, base + 32'd2, base + 32'd1, base},
                          4'(1 << (k % 4)), 1'b1, 5'(4 + k % 4), base + 32'(k % 4));
        end
        tbl[12] = mk(4'b0000, {5'd7, 5'd6, 5'd5, 5'd4}, {32'h203, 32'h202, 32'h201, 32'h200},
                     4'b0000, 1'b0, 5'd7, 32'h203);

        // Reset state, with every writer already requesting.
        rst = 1'b0; clear = 1'b0;
        req_valid = 4'b1111; req_addr = '0; req_data = '0;
        #12;
        chk("rst_we", write_enable, 1'b0);
        chk("rst_addr", write_addr, '0);
        chk("rst_data", write_data_in, '0);
        chk("rst_done", init_done, 1'b0);
        chk("rst_ready", req_ready, '0);
        @(posedge clk); #2;
        rst = 1'b1;

        check_sweep("init");
        req_valid = '0;
        @(posedge clk); #1;
        chk("post_init_we", write_enable, 1'b0);
        chk("post_init_addr_hold", write_addr, 5'd31);
        chk("post_init_data_hold", write_data_in, INIT);
        chk("mem0_init", mem[0], INIT);
        chk("mem31_init", mem[31], INIT);

        // Simultaneous requests, then all four streaming back to back.
        for (int r = 0; r < 13; r++) apply(tbl[r], $sformatf("vec%0d", r));
        chk("mem1", mem[1], 32'h42);
        chk("mem2", mem[2], 32'h69);
        chk("mem8", mem[8], 32'h77);
        for (int i = 0; i < 4; i++) chk($sformatf("mem%0d", 4 + i), mem[4+i], 32'h200 + 32'(i));

        // Writer 1 loses to writer 0, then withdraws; an invalid request must not write.
        apply(mk(4'b1000, {5'd3, 5'd0, 5'd0, 5'd0}, {32'h420, 32'h0, 32'h0, 32'h0},
                 4'b1000, 1'b1, 5'd3, 32'h420), "w420");
        apply(mk(4'b0011, {5'd0, 5'd0, 5'd10, 5'd9}, {32'h0, 32'h0, 32'h55, 32'h11},
                 4'b0001, 1'b1, 5'd9, 32'h11), "blk");
        apply(mk(4'b0000, {5'd0, 5'd0, 5'd10, 5'd3}, {32'h0, 32'h0, 32'h55, 32'hBAD},
                 4'b0000, 1'b0, 5'd9, 32'h11), "drop");
        @(posedge clk); #1;
        chk("mem10_untouched", mem[10], INIT);
        chk("mem3_kept", mem[3], 32'h420);
        chk("mem9", mem[9], 32'h11);

        // Clear in RUN while a write is still in flight.
        apply(mk(4'b0001, {5'd0, 5'd0, 5'd0, 5'd13}, {32'h0, 32'h0, 32'h0, 32'hAA},
                 4'b0001, 1'b1, 5'd13, 32'hAA), "pre_clr");
        clear = 1'b1;
        req_addr[0] = 5'd12; req_data[0] = 32'hC0DE;
        #1;
        chk("clr_ready", req_ready, '0);
        chk("clr_inflight_we", write_enable, 1'b1);
        chk("clr_inflight_addr", write_addr, 5'd13);
        @(posedge clk); #1;
        clear = 1'b0;
        chk("clr_done_low", init_done, 1'b0);
        chk("clr_we_low", write_enable, 1'b0);
        check_sweep("reinit");
        apply(mk(4'b0001, {5'd0, 5'd0, 5'd0, 5'd12}, {32'h0, 32'h0, 32'h0, 32'hC0DE},
                 4'b0001, 1'b1, 5'd12, 32'hC0DE), "post_clr");
        req_valid = '0;
        @(posedge clk); #1;
        chk("mem12_survives", mem[12], 32'hC0DE);
        chk("mem13_swept", mem[13], INIT);
        chk("mem3_swept", mem[3], INIT);

        // Asynchronous reset in the middle of a sweep.
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        repeat (11) @(posedge clk);
        #1;
        chk("mid_addr10", write_addr, 5'd10);
        rst = 1'b0;
        #1;
        chk("arst_we", write_enable, 1'b0);
        chk("arst_addr", write_addr, '0);
        chk("arst_data", write_data_in, '0);
        chk("arst_done", init_done, 1'b0);
        #2;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("restart_we", write_enable, 1'b1);
        chk("restart_addr0", write_addr, 5'd0);
        @(posedge clk); #1;
        chk("restart_addr1", write_addr, 5'd1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
